// File: rtl/pin_lock_if.sv
// pin_lock_if: digit-entry and status bundle for pin_lock_fsm.
// master drives digits/code, slave returns lock status.
interface pin_lock_if #(
  parameter int DIGIT_W    = 2,
  parameter int NUM_DIGITS = 3,
  parameter int MAX_TRIES  = 3
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);

  logic [DIGIT_W-1:0]            digit;
  logic                          digit_valid;
  logic                          clear;
  logic [NUM_DIGITS*DIGIT_W-1:0] code;
  logic                          unlock;
  logic                          lockout;
  logic                          bad_pin;
  logic [IW-1:0]                 digit_idx;
  logic [FW-1:0]                 fail_cnt;
  logic [1:0]                    state_dbg;

  modport master (
    output digit, digit_valid, clear, code,
    input  unlock, lockout, bad_pin,
    input  digit_idx, fail_cnt, state_dbg
  );

  modport slave (
    input  digit, digit_valid, clear, code,
    output unlock, lockout, bad_pin,
    output digit_idx, fail_cnt, state_dbg
  );
endinterface

// File: rtl/pin_lock_fsm.sv
// pin_lock_fsm: PIN-entry lock with failure counting and lockout.
// Optional inter-digit timeout built when PIN_LOCK_TIMEOUT_EN is defined.
module pin_lock_fsm #(
  parameter int DIGIT_W        = 2,
  parameter int NUM_DIGITS     = 3,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic       clk,
  input logic       rst,
  pin_lock_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int M1 = (UNLOCK_CYCLES > LOCKOUT_CYCLES)
                    ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MX = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MX + 1);

  typedef enum logic [1:0] {
    ENTRY   = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10
  } st_t;

  st_t           st, st_n;
  logic [IW-1:0] idx, idx_n;
  logic          mis, mis_n;
  logic [FW-1:0] fail, fail_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          bad, bad_n;

  logic [DIGIT_W-1:0] exp_d;
  logic               last;
  logic               mis_now;

  // expected digit for the current position, read live from code
  always_comb begin
    exp_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == IW'(k))
        exp_d = bus.code[k*DIGIT_W +: DIGIT_W];
  end

  assign last    = (idx == IW'(NUM_DIGITS - 1));
  assign mis_now = mis | (bus.digit != exp_d);

  // state, counters and registered pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= ENTRY;
      idx  <= '0;
      mis  <= 1'b0;
      fail <= '0;
      tmr  <= '0;
      bad  <= 1'b0;
    end else begin
      st   <= st_n;
      idx  <= idx_n;
      mis  <= mis_n;
      fail <= fail_n;
      tmr  <= tmr_n;
      bad  <= bad_n;
    end
  end

  // next-state: judge only after the final digit
  always_comb begin
    st_n   = st;
    idx_n  = idx;
    mis_n  = mis;
    fail_n = fail;
    tmr_n  = '0;
    bad_n  = 1'b0;
    unique case (st)
      ENTRY: begin
        if (bus.clear) begin
          idx_n = '0;
          mis_n = 1'b0;
        end else if (bus.digit_valid) begin
          if (last) begin
            idx_n = '0;
            mis_n = 1'b0;
            if (!mis_now) begin
              st_n   = OPEN;
              fail_n = '0;
            end else begin
              bad_n = 1'b1;
              if (fail == FW'(MAX_TRIES - 1)) begin
                fail_n = FW'(MAX_TRIES);
                st_n   = LOCKOUT;
              end else begin
                fail_n = fail + FW'(1);
              end
            end
          end else begin
            idx_n = idx + IW'(1);
            mis_n = mis_now;
          end
        end
`ifdef PIN_LOCK_TIMEOUT_EN
        else if (idx != '0) begin
          if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            idx_n = '0;
            mis_n = 1'b0;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
`else
        else begin
          tmr_n = '0;
        end
`endif
      end
      OPEN: begin
        if (bus.clear || tmr == TW'(UNLOCK_CYCLES - 1))
          st_n = ENTRY;
        else
          tmr_n = tmr + TW'(1);
      end
      LOCKOUT: begin
        if (tmr == TW'(LOCKOUT_CYCLES - 1)) begin
          st_n   = ENTRY;
          fail_n = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: st_n = ENTRY;
    endcase
  end

  assign bus.unlock    = (st == OPEN);
  assign bus.lockout   = (st == LOCKOUT);
  assign bus.bad_pin   = bad;
  assign bus.digit_idx = idx;
  assign bus.fail_cnt  = fail;
  assign bus.state_dbg = st;
endmodule

// File: tb/tb_pin_lock_fsm.sv
// tb_pin_lock_fsm: directed checks of pin_lock_fsm, default params.
// Code 01_10_00, correct sequence 00,10,01.
module tb_pin_lock_fsm;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   ul_cnt = 0;
  int   lk_cnt = 0;
  int   bp_cnt = 0;
  int   base;

  pin_lock_if #(.DIGIT_W(2), .NUM_DIGITS(3), .MAX_TRIES(3)) bus ();

  pin_lock_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // count output-high cycles away from the active edge
  always @(negedge clk) begin
    if (bus.unlock)  ul_cnt++;
    if (bus.lockout) lk_cnt++;
    if (bus.bad_pin) bp_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic good_pin();
    strobe(2'b00);
    strobe(2'b10);
    strobe(2'b01);
  endtask

  task automatic bad_seq();
    strobe(2'b00);
    strobe(2'b11);
    strobe(2'b01);
  endtask

  task automatic wait_unlock_low();
    for (int i = 0; i < 20 && bus.unlock; i++) tick();
    chk("unlock_end", 32'(bus.unlock), 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.digit       = '0;
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.code        = 6'b01_10_00;
    tick();
    tick();
    chk("rst_unlock",  32'(bus.unlock),    0);
    chk("rst_lockout", 32'(bus.lockout),   0);
    chk("rst_bad",     32'(bus.bad_pin),   0);
    chk("rst_idx",     32'(bus.digit_idx), 0);
    chk("rst_fail",    32'(bus.fail_cnt),  0);
    chk("rst_state",   32'(bus.state_dbg), 0);
    rst = 1'b0;
    tick();

    // correct PIN
    strobe(2'b00);
    chk("idx_1", 32'(bus.digit_idx), 1);
    strobe(2'b10);
    chk("idx_2", 32'(bus.digit_idx), 2);
    base = ul_cnt;
    strobe(2'b01);
    chk("open_unlock", 32'(bus.unlock),    1);
    chk("open_state",  32'(bus.state_dbg), 1);
    chk("open_fail",   32'(bus.fail_cnt),  0);
    chk("open_idx",    32'(bus.digit_idx), 0);
    wait_unlock_low();
    chk("open_len",    32'(ul_cnt - base), 4);
    chk("open_exit",   32'(bus.state_dbg), 0);

    // wrong PIN, no early rejection
    strobe(2'b00);
    strobe(2'b11);
    chk("wr_nobad",  32'(bus.bad_pin),   0);
    chk("wr_idx2",   32'(bus.digit_idx), 2);
    base = bp_cnt;
    strobe(2'b01);
    chk("wr_bad",    32'(bus.bad_pin),   1);
    chk("wr_fail",   32'(bus.fail_cnt),  1);
    chk("wr_idx0",   32'(bus.digit_idx), 0);
    chk("wr_unlock", 32'(bus.unlock),    0);
    tick();
    chk("wr_bad_off", 32'(bus.bad_pin),  0);
    chk("wr_pulses",  32'(bp_cnt - base), 1);

    // two more failures reach lockout
    bad_seq();
    chk("wr2_fail", 32'(bus.fail_cnt), 2);
    base = lk_cnt;
    bad_seq();
    chk("lk_on",    32'(bus.lockout),   1);
    chk("lk_state", 32'(bus.state_dbg), 2);
    chk("lk_fail",  32'(bus.fail_cnt),  3);
    chk("lk_bad",   32'(bus.bad_pin),   1);
    good_pin();
    chk("lk_ignore", 32'(bus.unlock),  0);
    chk("lk_still",  32'(bus.lockout), 1);
    for (int i = 0; i < 20 && bus.lockout; i++) tick();
    chk("lk_end",    32'(bus.lockout),   0);
    chk("lk_len",    32'(lk_cnt - base), 8);
    chk("lk_fail0",  32'(bus.fail_cnt),  0);
    chk("lk_idx0",   32'(bus.digit_idx), 0);
    good_pin();
    chk("lk_after_unlock", 32'(bus.unlock), 1);
    wait_unlock_low();

    // clear with simultaneous digit is not a failure
    base = bp_cnt;
    strobe(2'b00);
    strobe(2'b10);
    bus.clear = 1'b1;
    strobe(2'b01);
    bus.clear = 1'b0;
    chk("clr_idx",    32'(bus.digit_idx), 0);
    chk("clr_unlock", 32'(bus.unlock),    0);
    chk("clr_fail",   32'(bus.fail_cnt),  0);
    good_pin();
    chk("clr_then_open", 32'(bus.unlock), 1);
    chk("clr_nobad",  32'(bp_cnt - base), 0);
    wait_unlock_low();

    // async reset in OPEN, cycle 2
    good_pin();
    tick();
    chk("ro_pre", 32'(bus.unlock), 1);
    rst = 1'b1;
    #1;
    chk("ro_unlock", 32'(bus.unlock),    0);
    chk("ro_state",  32'(bus.state_dbg), 0);
    #1;
    rst = 1'b0;
    tick();

    // async reset in LOCKOUT, cycle 3
    bad_seq();
    bad_seq();
    bad_seq();
    tick();
    tick();
    chk("rl_pre", 32'(bus.lockout), 1);
    rst = 1'b1;
    #1;
    chk("rl_lockout", 32'(bus.lockout),   0);
    chk("rl_fail",    32'(bus.fail_cnt),  0);
    chk("rl_bad",     32'(bus.bad_pin),   0);
    chk("rl_state",   32'(bus.state_dbg), 0);
    #1;
    rst = 1'b0;
    tick();

    // idle after one digit
    base = bp_cnt;
    strobe(2'b00);
    for (int i = 0; i < 16; i++) tick();
`ifdef PIN_LOCK_TIMEOUT_EN
    chk("to_idx", 32'(bus.digit_idx), 0);
`else
    chk("to_idx", 32'(bus.digit_idx), 1);
`endif
    chk("to_nobad", 32'(bp_cnt - base), 0);
    chk("to_fail",  32'(bus.fail_cnt),  0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
